alu_operand_stage: RTL and testbench

- Issue stage directly upstream of the ALU.
- Accepts one 32-bit RV32I instruction per handshake, decodes OP (0110011) and OP-IMM (0010011), and reads its 32x32 register file.
- Drives registered fun3, func7, ALUin1 and ALUin2 to the ALU.
- Holds a per-register busy scoreboard, cleared by the writeback port, and stalls on register hazards.

---
 rtl/alu_operand_stage.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Purpose  : Issue stage directly upstream of the ALU. Accepts one RV32I
//            instruction per valid/ready handshake, decodes OP (0110011) and
//            OP-IMM (0010011), reads the 32x32 register file and presents a
//            registered operand bundle (fun3, func7, ALUin1, ALUin2, rd,
//            illegal) to the ALU. A per-register busy scoreboard, set on issue
//            and cleared by the writeback port, stalls register hazards
//            (RAW on rs1/rs2 and WAW on rd).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   in_valid   in   1     instruction valid
//   in_ready   out  1     stage can accept an instruction this cycle
//   instr      in   32    RV32I instruction word
//   out_valid  out  1     operand bundle valid
//   out_ready  in   1     downstream accepts the bundle
//   fun3       out  3     instr[14:12] of the issued instruction
//   func7      out  7     ALU function-7 field
//   ALUin1     out  XLEN  rs1 operand
//   ALUin2     out  XLEN  rs2 operand or immediate
//   rd         out  5     destination register of the issued bundle
//   illegal    out  1     issued bundle is unsupported/illegal
//   wb_en      in   1     writeback strobe
//   wb_rd      in   5     writeback register
//   wb_data    in   XLEN  writeback value
// ----------------------------------------------------------------------------
// Build option
//   ALU_OPSTAGE_WB_BYPASS_EN : when defined, a writeback in the same cycle as
//   a stalled read clears the hazard immediately and wb_data is forwarded
//   into the operands (zero-bubble issue). When undefined, the register file
//   and scoreboard are sampled before the writeback takes effect, so the
//   consumer issues one cycle after the writeback.
// ============================================================================
module alu_operand_stage #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2:0]      fun3,
   output logic [6:0]      func7,
   output logic [XLEN-1:0] ALUin1,
   output logic [XLEN-1:0] ALUin2,
   output logic [4:0]      rd,
   output logic            illegal,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data
);

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [2:0] F3_ADD    = 3'b000;
   localparam logic [2:0] F3_SLL    = 3'b001;
   localparam logic [2:0] F3_SR     = 3'b101;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [XLEN-1:0]  rf_q [NREGS];
   logic [NREGS-1:0] busy_q,    busy_d;

   logic             out_valid_q, out_valid_d;
   logic [2:0]       fun3_q,      fun3_d;
   logic [6:0]       func7_q,     func7_d;
   logic [XLEN-1:0]  alu1_q,      alu1_d;
   logic [XLEN-1:0]  alu2_q,      alu2_d;
   logic [4:0]       rd_q,        rd_d;
   logic             illegal_q,   illegal_d;

   // ------------------------------------------------------------------------
   // Instruction fields
   // ------------------------------------------------------------------------
   logic [6:0] opc;
   logic [4:0] rd_idx;
   logic [2:0] f3;
   logic [4:0] rs1_idx;
   logic [4:0] rs2_idx;
   logic [6:0] f7;

   assign opc     = instr[6:0];
   assign rd_idx  = instr[11:7];
   assign f3      = instr[14:12];
   assign rs1_idx = instr[19:15];
   assign rs2_idx = instr[24:20];
   assign f7      = instr[31:25];

   // ------------------------------------------------------------------------
   // Writeback clear mask (x0 writes are dropped entirely)
   // ------------------------------------------------------------------------
   logic             wb_act;
   logic [NREGS-1:0] wb_clr_mask;

   assign wb_act = wb_en && (wb_rd != 5'd0);

   always_comb begin
      wb_clr_mask = '0;
      if (wb_act) begin
         wb_clr_mask[wb_rd] = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Register file read ports. x0 always reads zero.
   // ------------------------------------------------------------------------
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;

   always_comb begin
      rs1_val = '0;
      if (rs1_idx != 5'd0) begin
`ifdef ALU_OPSTAGE_WB_BYPASS_EN
         if (wb_en && (wb_rd == rs1_idx)) begin
            rs1_val = wb_data;
         end else begin
            rs1_val = rf_q[rs1_idx];
         end
`else
         rs1_val = rf_q[rs1_idx];
`endif
      end
   end

   always_comb begin
      rs2_val = '0;
      if (rs2_idx != 5'd0) begin
`ifdef ALU_OPSTAGE_WB_BYPASS_EN
         if (wb_en && (wb_rd == rs2_idx)) begin
            rs2_val = wb_data;
         end else begin
            rs2_val = rf_q[rs2_idx];
         end
`else
         rs2_val = rf_q[rs2_idx];
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------------
   logic            dec_legal;
   logic            dec_uses_rs2;
   logic [6:0]      dec_func7;
   logic [XLEN-1:0] dec_op2;

   always_comb begin
      dec_legal    = 1'b0;
      dec_uses_rs2 = 1'b0;
      dec_func7    = F7_BASE;
      dec_op2      = '0;
      if (opc == OPC_OP) begin
         dec_uses_rs2 = 1'b1;
         dec_func7    = f7;
         dec_op2      = rs2_val;
         // Alternate encoding is only meaningful for SUB and SRA.
         dec_legal    = (f7 == F7_BASE) ||
                        ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
      end else if (opc == OPC_OPIMM) begin
         if ((f3 == F3_SLL) || (f3 == F3_SR)) begin
            dec_func7 = f7;
            dec_op2   = {{(XLEN-5){1'b0}}, instr[24:20]};
            dec_legal = (f7 == F7_BASE) || ((f7 == F7_ALT) && (f3 == F3_SR));
         end else begin
            // Upper immediate bits must never look like a SUB selector to
            // the ALU, so func7 is forced to the base encoding here.
            dec_func7 = F7_BASE;
            dec_op2   = {{(XLEN-12){instr[31]}}, instr[31:20]};
            dec_legal = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Hazard detection against the scoreboard
   // ------------------------------------------------------------------------
   logic [NREGS-1:0] busy_eff;
   logic             hazard;

   always_comb begin
`ifdef ALU_OPSTAGE_WB_BYPASS_EN
      // A same-cycle writeback resolves the dependency immediately.
      busy_eff = busy_q & ~wb_clr_mask;
`else
      busy_eff = busy_q;
`endif
      busy_eff[0] = 1'b0;
   end

   // Illegal instructions never read or write registers, so they never stall.
   assign hazard = dec_legal &&
                   (busy_eff[rs1_idx] ||
                    (dec_uses_rs2 && busy_eff[rs2_idx]) ||
                    busy_eff[rd_idx]);

   logic accept;

   assign in_ready = (!out_valid_q || out_ready) && !hazard;
   assign accept   = in_valid && in_ready;

   // ------------------------------------------------------------------------
   // Next-state: scoreboard (issue-set has priority over writeback-clear)
   // ------------------------------------------------------------------------
   logic [NREGS-1:0] set_mask;

   always_comb begin
      set_mask = '0;
      if (accept && dec_legal && (rd_idx != 5'd0)) begin
         set_mask[rd_idx] = 1'b1;
      end
      busy_d = (busy_q & ~wb_clr_mask) | set_mask;
   end

   // ------------------------------------------------------------------------
   // Next-state: output bundle
   // ------------------------------------------------------------------------
   always_comb begin
      out_valid_d = out_valid_q;
      fun3_d      = fun3_q;
      func7_d     = func7_q;
      alu1_d      = alu1_q;
      alu2_d      = alu2_q;
      rd_d        = rd_q;
      illegal_d   = illegal_q;
      if (accept) begin
         out_valid_d = 1'b1;
         fun3_d      = f3;
         illegal_d   = !dec_legal;
         // Illegal bundles carry no destination and zeroed operands so the
         // downstream never acts on stale register contents.
         if (dec_legal) begin
            func7_d = dec_func7;
            alu1_d  = rs1_val;
            alu2_d  = dec_op2;
            rd_d    = rd_idx;
         end else begin
            func7_d = F7_BASE;
            alu1_d  = '0;
            alu2_d  = '0;
            rd_d    = 5'd0;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Sequential: bundle and scoreboard
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         fun3_q      <= '0;
         func7_q     <= '0;
         alu1_q      <= '0;
         alu2_q      <= '0;
         rd_q        <= '0;
         illegal_q   <= 1'b0;
         busy_q      <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         fun3_q      <= fun3_d;
         func7_q     <= func7_d;
         alu1_q      <= alu1_d;
         alu2_q      <= alu2_d;
         rd_q        <= rd_d;
         illegal_q   <= illegal_d;
         busy_q      <= busy_d;
      end
   end

   // ------------------------------------------------------------------------
   // Sequential: register file (entry 0 is never written)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            rf_q[i] <= '0;
         end
      end else if (wb_act) begin
         rf_q[wb_rd] <= wb_data;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign out_valid = out_valid_q;
   assign fun3      = fun3_q;
   assign func7     = func7_q;
   assign ALUin1    = alu1_q;
   assign ALUin2    = alu2_q;
   assign rd        = rd_q;
   assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_stage
// Purpose  : Self-checking bench for alu_operand_stage. Directed steps from
//            the test plan followed by randomized traffic, all compared
//            against an instruction-level reference model of the issue stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

   localparam int XLEN = 32;

   localparam logic [31:0] I_ADD3  = 32'h002081B3; // add  x3,x1,x2
   localparam logic [31:0] I_SUB4  = 32'h40208233; // sub  x4,x1,x2
   localparam logic [31:0] I_ADDI5 = 32'hFFF08293; // addi x5,x1,-1
   localparam logic [31:0] I_SRAI6 = 32'h4030D313; // srai x6,x1,3
   localparam logic [31:0] I_LW7   = 32'h0040A383; // lw   x7,4(x1)  (unsupported)
   localparam logic [31:0] I_AND7  = 32'h0011F3B3; // and  x7,x3,x1
   localparam logic [31:0] I_ADD8  = 32'h00208433; // add  x8,x1,x2
   localparam logic [31:0] I_SUB9  = 32'h402084B3; // sub  x9,x1,x2

`ifdef ALU_OPSTAGE_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic            clk       = 1'b0;
   logic            rst_n     = 1'b0;
   logic            in_valid  = 1'b0;
   logic [31:0]     instr     = '0;
   logic            out_ready = 1'b0;
   logic            wb_en     = 1'b0;
   logic [4:0]      wb_rd     = '0;
   logic [XLEN-1:0] wb_data   = '0;

   logic            in_ready;
   logic            out_valid;
   logic [2:0]      fun3;
   logic [6:0]      func7;
   logic [XLEN-1:0] ALUin1;
   logic [XLEN-1:0] ALUin2;
   logic [4:0]      rd;
   logic            illegal;

   alu_operand_stage #(.XLEN(XLEN), .NREGS(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fun3      (fun3),
      .func7     (func7),
      .ALUin1    (ALUin1),
      .ALUin2    (ALUin2),
      .rd        (rd),
      .illegal   (illegal),
      .wb_en     (wb_en),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // ------------------------------------------------------------------------
   // Reference model: architectural registers, busy set, pending bundle
   // ------------------------------------------------------------------------
   logic [31:0] m_rf   [32];
   bit          m_busy [32];
   bit          m_ov;
   logic [2:0]  m_f3;
   logic [6:0]  m_f7;
   logic [31:0] m_a1, m_a2;
   logic [4:0]  m_rd;
   bit          m_ill;

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) begin
         m_rf[i]   = '0;
         m_busy[i] = 1'b0;
      end
      m_ov = 1'b0; m_f3 = '0; m_f7 = '0; m_a1 = '0; m_a2 = '0; m_rd = '0; m_ill = 1'b0;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (BYP && wb_en && (wb_rd == r)) return wb_data;
      return m_rf[r];
   endfunction

   function automatic bit m_is_busy(input logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      if (BYP && wb_en && (wb_rd == r)) return 1'b0;
      return m_busy[r];
   endfunction

   function automatic void m_decode(input logic [31:0] ins, output bit legal, output bit uses2,
                                    output logic [6:0] f7o, output logic [31:0] a1, output logic [31:0] a2);
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] raw7;
      opc = ins[6:0]; f3 = ins[14:12]; raw7 = ins[31:25];
      legal = 1'b0; uses2 = 1'b0; f7o = 7'd0; a1 = '0; a2 = '0;
      if (opc == 7'b0110011) begin
         uses2 = 1'b1;
         legal = (raw7 == 7'h00) || (raw7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
         f7o = raw7;
         a1 = m_read(ins[19:15]);
         a2 = m_read(ins[24:20]);
      end else if (opc == 7'b0010011) begin
         a1 = m_read(ins[19:15]);
         if (f3 == 3'd1 || f3 == 3'd5) begin
            a2 = 32'(ins[24:20]);
            f7o = raw7;
            legal = (raw7 == 7'h00) || (raw7 == 7'h20 && f3 == 3'd5);
         end else begin
            a2 = 32'($signed(ins[31:20]));
            f7o = 7'd0;
            legal = 1'b1;
         end
      end
      if (!legal) begin
         a1 = '0; a2 = '0; f7o = 7'd0;
      end
   endfunction

   // ------------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      check("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
         check("fun3",    32'(fun3),    32'(m_f3));
         check("rd",      32'(rd),      32'(m_rd));
         check("illegal", 32'(illegal), 32'(m_ill));
         check("ALUin1",  ALUin1,       m_a1);
         check("ALUin2",  ALUin2,       m_a2);
         if (!m_ill) check("func7", 32'(func7), 32'(m_f7));
      end
   endtask

   task automatic drive(input bit v, input logic [31:0] ins, input bit ordy,
                        input bit we, input logic [4:0] wr, input logic [31:0] wd);
      in_valid = v; instr = ins; out_ready = ordy; wb_en = we; wb_rd = wr; wb_data = wd;
   endtask

   // One clock cycle: check in_ready, advance the model at the edge, check outputs.
   task automatic step();
      bit          legal, uses2, haz, rdy, acc;
      logic [6:0]  f7;
      logic [31:0] a1, a2;
      logic [4:0]  rdf;
      #1;
      m_decode(instr, legal, uses2, f7, a1, a2);
      rdf = instr[11:7];
      haz = legal && (m_is_busy(instr[19:15]) || (uses2 && m_is_busy(instr[24:20])) || m_is_busy(rdf));
      rdy = (!m_ov || out_ready) && !haz;
      check("in_ready", 32'(in_ready), 32'(rdy));
      acc = in_valid && rdy;
      @(posedge clk);
      if (wb_en && wb_rd != 5'd0) begin
         m_rf[wb_rd]   = wb_data;
         m_busy[wb_rd] = 1'b0;
      end
      if (acc) begin
         m_ov = 1'b1; m_f3 = instr[14:12]; m_f7 = f7; m_a1 = a1; m_a2 = a2;
         m_rd = legal ? rdf : 5'd0; m_ill = !legal;
         if (legal && rdf != 5'd0) m_busy[rdf] = 1'b1;
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
      #1;
      check_outputs();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0] rs1, rs2, rdr;
      logic [2:0] f3;
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rdr = 5'($urandom_range(0, 7));
      f3  = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 6))
         0: return {7'h00, rs2, rs1, f3, rdr, 7'b0110011};
         1: return {7'h20, rs2, rs1, ($urandom_range(0, 1) != 0) ? 3'd5 : 3'd0, rdr, 7'b0110011};
         2: return {7'($urandom), rs2, rs1, f3, rdr, 7'b0110011};
         3: begin
            if (f3 == 3'd1 || f3 == 3'd5) f3 = 3'd0;
            return {12'($urandom), rs1, f3, rdr, 7'b0010011};
         end
         4: begin
            if ($urandom_range(0, 1) != 0) return {7'h00, rs2, rs1, 3'd1, rdr, 7'b0010011};
            return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, rs2, rs1, 3'd5, rdr, 7'b0010011};
         end
         5: return {7'($urandom), rs2, rs1, ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5, rdr, 7'b0010011};
         default: return $urandom;
      endcase
   endfunction

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_fun3",      32'(fun3),      32'd0);
      check("rst_func7",     32'(func7),     32'd0);
      check("rst_ALUin1",    ALUin1,         32'd0);
      check("rst_ALUin2",    ALUin2,         32'd0);
      check("rst_rd",        32'(rd),        32'd0);
      check("rst_illegal",   32'(illegal),   32'd0);
      rst_n = 1'b1;

      // Seed x1=5, x2=7.
      drive(0, 32'd0, 1, 1, 5'd1, 32'd5); step();
      drive(0, 32'd0, 1, 1, 5'd2, 32'd7); step();

      drive(1, I_ADD3, 1, 0, 5'd0, 32'd0); step();
      check("add_valid", 32'(out_valid), 32'd1);
      check("add_func7", 32'(func7),     32'd0);
      check("add_a1",    ALUin1,         32'd5);
      check("add_a2",    ALUin2,         32'd7);
      check("add_rd",    32'(rd),        32'd3);

      drive(1, I_SUB4, 1, 0, 5'd0, 32'd0); step();
      check("sub_func7", 32'(func7), 32'h20);
      check("sub_a1",    ALUin1,     32'd5);
      check("sub_a2",    ALUin2,     32'd7);

      drive(1, I_ADDI5, 1, 0, 5'd0, 32'd0); step();
      check("addi_a2",    ALUin2,         32'hFFFF_FFFF);
      check("addi_func7", 32'(func7),     32'd0);

      drive(1, I_SRAI6, 1, 0, 5'd0, 32'd0); step();
      check("srai_fun3",  32'(fun3),  32'd5);
      check("srai_func7", 32'(func7), 32'h20);
      check("srai_a2",    ALUin2,     32'd3);

      drive(1, I_LW7, 1, 0, 5'd0, 32'd0); step();
      check("ill_flag", 32'(illegal), 32'd1);
      check("ill_rd",   32'(rd),      32'd0);

      // Retire x3..x6.
      drive(0, 32'd0, 1, 1, 5'd4, 32'd1); step();
      drive(0, 32'd0, 1, 1, 5'd5, 32'd2); step();
      drive(0, 32'd0, 1, 1, 5'd6, 32'd3); step();
      drive(0, 32'd0, 1, 1, 5'd3, 32'd9); step();

      // RAW stall on x3.
      drive(1, I_ADD3, 1, 0, 5'd0, 32'd0); step();
      drive(1, I_AND7, 1, 0, 5'd0, 32'd0);
      step(); check("raw_stall0", 32'(in_ready), 32'd0);
      step(); check("raw_stall1", 32'(in_ready), 32'd0);
      drive(1, I_AND7, 1, 1, 5'd3, 32'd12); step();
`ifdef ALU_OPSTAGE_WB_BYPASS_EN
      check("byp_rd", 32'(rd),  32'd7);
      check("byp_a1", ALUin1,   32'd12);
`else
      check("nobyp_bubble", 32'(out_valid), 32'd0);
      drive(1, I_AND7, 1, 0, 5'd0, 32'd0); step();
      check("nobyp_rd", 32'(rd), 32'd7);
      check("nobyp_a1", ALUin1,  32'd12);
`endif
      check("and_a2", ALUin2, 32'd5);

      // Backpressure for three cycles with a new instruction waiting.
      drive(1, I_ADD8, 0, 0, 5'd0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_a1",       ALUin1,        32'd12);
      end
      drive(1, I_ADD8, 1, 0, 5'd0, 32'd0); step();
      check("release_rd", 32'(rd), 32'd8);

      // Asynchronous reset in the middle of a hold.
      drive(1, I_SUB9, 0, 0, 5'd0, 32'd0); step();
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_ALUin1",    ALUin1,         32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, I_ADD3, 1, 0, 5'd0, 32'd0); step();
      check("post_rst_x1", ALUin1, 32'd0);
      check("post_rst_x2", ALUin2, 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
               $urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)), $urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
